cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//   Shares the single cache-line memory port between the i_cache miss path (read-only) and the
//   d_cache miss/writeback path. Round-robin arbitration, one outstanding transaction; registered
//   request copy to memory, response routed back to the winner with a one-cycle ready pulse.
//   Sits between the two cache controllers' mem_req/mem_data ports and the memory/bus bridge.
// PARAMETERS
//   ADDR_W   32    byte address width
//   LINE_W   128   cache line width (16-byte lines)
//   TMO_CYC  1024  cycles in BUSY before timeout flag sets
// PORTS
//   clk_i            in   1       clock
//   rst_ni           in   1       async active-low reset
//   ic_req_valid_i   in   1       i_cache line-read request, held until ic_rsp_ready_o
//   ic_req_addr_i    in   ADDR_W  i_cache line address
//   ic_rsp_data_o    out  LINE_W  line returned to i_cache
//   ic_rsp_ready_o   out  1       one-cycle completion pulse to i_cache
//   dc_req_valid_i   in   1       d_cache request, held until dc_rsp_ready_o
//   dc_req_rw_i      in   1       1 = line write, 0 = line read
//   dc_req_addr_i    in   ADDR_W  d_cache line address
//   dc_req_data_i    in   LINE_W  writeback line
//   dc_rsp_data_o    out  LINE_W  line returned to d_cache
//   dc_rsp_ready_o   out  1       one-cycle completion pulse to d_cache
//   mem_req_valid_o  out  1       request to memory, held until mem_rsp_ready_i
//   mem_req_rw_o     out  1       1 = write
//   mem_req_addr_o   out  ADDR_W  registered address
//   mem_req_data_o   out  LINE_W  registered write data
//   mem_rsp_data_i   in   LINE_W  read data from memory
//   mem_rsp_ready_i  in   1       memory completion, 1 cycle
//   grant_o          out  1       owner of current/last txn: 0 = IC, 1 = DC
//   tmo_err_o        out  1       sticky timeout flag
// BEHAVIOUR
// - Reset (async, rst_ni=0): state IDLE; every output 0; last_grant = DC; tmo counter 0.
// - FSM IDLE -> BUSY -> DONE -> IDLE.
// - IDLE: if only one valid, grant it; if both, grant the one != last_grant (first tie -> IC).
//   On grant: register addr/rw/data (IC rw forced 0), set grant_o/last_grant, go BUSY.
//   No valid: stay IDLE.
// - BUSY: mem_req_valid_o=1 with registered fields, stable until mem_rsp_ready_i.
//   Request valid in IDLE at cycle 0 -> mem_req_valid_o=1 in cycle 1.
//   On mem_rsp_ready_i=1: latch mem_rsp_data_i into winner's rsp_data, go DONE;
//   mem_req_valid_o=0 from the next cycle.
// - DONE (exactly 1 cycle): winner's rsp_ready_o=1, other rsp_ready_o=0; then IDLE.
//   The gap cycle lets the requester drop valid, so it is never re-granted stale.
// - rsp_data_o holds its value until that requester's next completion.
//   On a DC write completion, dc_rsp_data_o = mem_rsp_data_i (don't-care to d_cache).
// - Requests arriving outside IDLE wait; the non-winner keeps valid high and wins next IDLE.
// - Requester dropping valid during BUSY: transaction still completes, ready still pulses.
// - mem_rsp_ready_i outside BUSY: ignored, no state or data change.
// - Timeout: counter increments each BUSY cycle, clears on leaving BUSY. Reaching TMO_CYC sets
//   tmo_err_o (sticky until reset); the transaction keeps waiting, no abort.
// - Reset mid-transaction: immediate return to reset values; the in-flight response is lost.
//   Requesters must reissue.
// TESTING
// 1 IC-only: ic valid addr 0x0000_1230 at cyc0, mem ready cyc4 data 0xA5.. -> mem_req_valid_o
//   cyc1-4 rw=0 addr 0x1230, ic_rsp_ready_o=1 only cyc5, ic_rsp_data_o=0xA5..
// 2 Tie: both valid cyc0 -> IC served first, DC granted in the IDLE after IC's DONE;
//   next tie -> DC first (alternation).
// 3 DC write: rw=1 addr 0x8000_0040 data 0x1122.. -> mem_req_rw_o=1, data/addr match,
//   dc_rsp_ready_o 1 cycle, ic_rsp_ready_o stays 0.
// 4 Stray mem_rsp_ready_i in IDLE and in DONE -> no ready pulses, rsp_data unchanged.
// 5 TMO_CYC=8, no mem ready -> tmo_err_o rises after 8 BUSY cycles and stays 1.
//   Later ready completes normally.
// 6 rst_ni low during BUSY -> all outputs 0 asynchronously.
//   After release, the held IC request is re-granted and completes.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Cache-line memory port bundle: i_cache and d_cache request/response plus memory side.
// slave = arbiter view, master = the surrounding caches/memory.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ic_req_valid_i;
    logic [ADDR_W-1:0] ic_req_addr_i;
    logic [LINE_W-1:0] ic_rsp_data_o;
    logic              ic_rsp_ready_o;

    logic              dc_req_valid_i;
    logic              dc_req_rw_i;
    logic [ADDR_W-1:0] dc_req_addr_i;
    logic [LINE_W-1:0] dc_req_data_i;
    logic [LINE_W-1:0] dc_rsp_data_o;
    logic              dc_rsp_ready_o;

    logic              mem_req_valid_o;
    logic              mem_req_rw_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic [LINE_W-1:0] mem_req_data_o;
    logic [LINE_W-1:0] mem_rsp_data_i;
    logic              mem_rsp_ready_i;

    modport slave (
        input  ic_req_valid_i, ic_req_addr_i,
        input  dc_req_valid_i, dc_req_rw_i, dc_req_addr_i, dc_req_data_i,
        input  mem_rsp_data_i, mem_rsp_ready_i,
        output ic_rsp_data_o, ic_rsp_ready_o,
        output dc_rsp_data_o, dc_rsp_ready_o,
        output mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o
    );

    modport master (
        output ic_req_valid_i, ic_req_addr_i,
        output dc_req_valid_i, dc_req_rw_i, dc_req_addr_i, dc_req_data_i,
        output mem_rsp_data_i, mem_rsp_ready_i,
        input  ic_rsp_data_o, ic_rsp_ready_o,
        input  dc_rsp_data_o, dc_rsp_ready_o,
        input  mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port between i_cache and d_cache.
// Latency: request in IDLE -> mem request next cycle; ready pulse one cycle after mem completion.
// Backpressure: one transaction in flight; the loser holds valid and wins the next IDLE.
module cache_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TMO_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    cache_mem_arbiter_if.slave  bus,
    output logic                grant_o,
    output logic                tmo_err_o
);
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TMO_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_grant_en;
    logic              w_grant_sel;
    logic              w_mem_vld;
    logic              w_done;
    logic              w_mem_cpl;

    logic              r_grant;
    logic              r_last_grant;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_data;
    logic [LINE_W-1:0] r_ic_rsp;
    logic [LINE_W-1:0] r_dc_rsp;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_tmo_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_grant_sel = r_last_grant;
        w_mem_vld   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ic_req_valid_i || bus.dc_req_valid_i) begin
                    w_grant_en  = 1'b1;
                    // On a tie, alternate away from the previous owner.
                    w_grant_sel = (bus.ic_req_valid_i && bus.dc_req_valid_i) ?
                                  ~r_last_grant : bus.dc_req_valid_i;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_mem_vld = 1'b1;
                if (bus.mem_rsp_ready_i) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_mem_cpl = w_mem_vld & bus.mem_rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_ic_rsp     <= '0;
            r_dc_rsp     <= '0;
        end else begin
            if (w_grant_en) begin
                r_grant      <= w_grant_sel;
                r_last_grant <= w_grant_sel;
                r_rw         <= w_grant_sel & bus.dc_req_rw_i;
                r_addr       <= w_grant_sel ? bus.dc_req_addr_i : bus.ic_req_addr_i;
                r_data       <= w_grant_sel ? bus.dc_req_data_i : '0;
            end
            if (w_mem_cpl) begin
                if (r_grant) r_dc_rsp <= bus.mem_rsp_data_i;
                else         r_ic_rsp <= bus.mem_rsp_data_i;
            end
        end
    end

    // Timeout only flags a stuck memory; the transaction keeps waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            if (r_tmo_cnt != TMO_MAX)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (r_tmo_cnt == TMO_LAST) r_tmo_err <= 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign bus.mem_req_valid_o = w_mem_vld;
    assign bus.mem_req_rw_o    = r_rw;
    assign bus.mem_req_addr_o  = r_addr;
    assign bus.mem_req_data_o  = r_data;
    assign bus.ic_rsp_data_o   = r_ic_rsp;
    assign bus.dc_rsp_data_o   = r_dc_rsp;
    assign bus.ic_rsp_ready_o  = w_done & ~r_grant;
    assign bus.dc_rsp_ready_o  = w_done & r_grant;
    assign grant_o             = r_grant;
    assign tmo_err_o           = r_tmo_err;
endmodule
